// File: rtl/axis_aud_pkg.sv
// Shared constants, beat payload type and helpers for the audio channel FIFO.
package axis_aud_pkg;

  localparam int unsigned AUD_DATA_W = 32;
  localparam int unsigned AUD_TID_W  = 3;
  localparam int unsigned AUD_NUM_CH = 2;
  localparam int unsigned AUD_DEPTH  = 16;
  localparam int unsigned ERR_CNT_W  = 8;

  typedef struct packed {
    logic [AUD_TID_W-1:0]  tid;
    logic [AUD_DATA_W-1:0] tdata;
  } aud_beat_t;

  // Saturating increment for the violation counter.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/axis_aud_seq_chk.sv
// Channel-sequence checker: tracks the expected channel ID of the next accepted
// beat and flags/counts out-of-order or out-of-range IDs.
module axis_aud_seq_chk
  import axis_aud_pkg::*;
#(
  parameter int unsigned TID_W  = AUD_TID_W,
  parameter int unsigned NUM_CH = AUD_NUM_CH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fire,
  input  logic [TID_W-1:0]     tid,
  output logic                 beat_ok_c,
  output logic                 ch_err,
  output logic [ERR_CNT_W-1:0] ch_err_cnt
);

  localparam logic [TID_W-1:0] LAST_CH = TID_W'(NUM_CH - 1);

  logic [TID_W-1:0] exp_ch;

  assign beat_ok_c = (tid == exp_ch) && ({1'b0, tid} < (TID_W + 1)'(NUM_CH));

  // Expected channel advances only on good beats; bad beats pulse and count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_ch     <= '0;
      ch_err     <= 1'b0;
      ch_err_cnt <= '0;
    end else begin
      ch_err <= fire && !beat_ok_c;
      if (fire) begin
        if (beat_ok_c) begin
          exp_ch <= (exp_ch == LAST_CH) ? '0 : exp_ch + TID_W'(1);
        end else begin
          ch_err_cnt <= sat_inc(ch_err_cnt);
        end
      end
    end
  end

endmodule

// File: rtl/axis_aud_ch_fifo.sv
// AXI-Stream audio FIFO with optional channel-sequence checking.
// Define AXIS_AUD_CH_CHECK_EN to enable the checker (drops out-of-sequence beats).
module axis_aud_ch_fifo
  import axis_aud_pkg::*;
#(
  parameter int unsigned DATA_W = AUD_DATA_W,
  parameter int unsigned TID_W  = AUD_TID_W,
  parameter int unsigned NUM_CH = AUD_NUM_CH,
  parameter int unsigned DEPTH  = AUD_DEPTH
) (
  input  logic                     s_axis_aud_aclk,
  input  logic                     s_axis_aud_areset,
  input  logic [DATA_W-1:0]        s_axis_aud_tdata,
  input  logic [TID_W-1:0]         s_axis_aud_tid,
  input  logic                     s_axis_aud_tvalid,
  output logic                     s_axis_aud_tready,
  output logic [DATA_W-1:0]        m_axis_aud_tdata,
  output logic [TID_W-1:0]         m_axis_aud_tid,
  output logic                     m_axis_aud_tvalid,
  input  logic                     m_axis_aud_tready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     ch_err,
  output logic [ERR_CNT_W-1:0]     ch_err_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end
  if (NUM_CH < 1 || NUM_CH > (2 ** TID_W)) begin : g_bad_num_ch
    $error("NUM_CH must be in 1..2**TID_W");
  end

  typedef struct packed {
    logic [TID_W-1:0]  tid;
    logic [DATA_W-1:0] tdata;
  } beat_t;

  beat_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             rdy_arm;
  logic             push;
  logic             pop;
  logic             beat_ok;
  logic             store;

  assign s_axis_aud_tready = rdy_arm && (fifo_level != LVL_W'(DEPTH));
  assign m_axis_aud_tvalid = (fifo_level != '0);
  assign push  = s_axis_aud_tvalid && s_axis_aud_tready;
  assign pop   = m_axis_aud_tvalid && m_axis_aud_tready;
  assign store = push && beat_ok;

  assign m_axis_aud_tid   = mem[rd_ptr].tid;
  assign m_axis_aud_tdata = mem[rd_ptr].tdata;

`ifdef AXIS_AUD_CH_CHECK_EN
  axis_aud_seq_chk #(
    .TID_W  (TID_W),
    .NUM_CH (NUM_CH)
  ) u_seq_chk (
    .clk        (s_axis_aud_aclk),
    .rst        (s_axis_aud_areset),
    .fire       (push),
    .tid        (s_axis_aud_tid),
    .beat_ok_c  (beat_ok),
    .ch_err     (ch_err),
    .ch_err_cnt (ch_err_cnt)
  );
`else
  assign beat_ok    = 1'b1;
  assign ch_err     = 1'b0;
  assign ch_err_cnt = '0;
`endif

  // Ingress stays closed during reset and opens on the first edge after it.
  always_ff @(posedge s_axis_aud_aclk or posedge s_axis_aud_areset) begin
    if (s_axis_aud_areset) begin
      rdy_arm <= 1'b0;
    end else begin
      rdy_arm <= 1'b1;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge s_axis_aud_aclk or posedge s_axis_aud_areset) begin
    if (s_axis_aud_areset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({store, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge s_axis_aud_aclk) begin
    if (store) mem[wr_ptr] <= '{tid: s_axis_aud_tid, tdata: s_axis_aud_tdata};
  end

endmodule

// File: tb/tb_axis_aud_ch_fifo.sv
// Directed self-checking bench for axis_aud_ch_fifo at default parameters;
// expectations follow AXIS_AUD_CH_CHECK_EN when it is defined.
module tb_axis_aud_ch_fifo;
  import axis_aud_pkg::*;

  localparam int unsigned DATA_W = AUD_DATA_W;
  localparam int unsigned TID_W  = AUD_TID_W;
  localparam int unsigned NUM_CH = AUD_NUM_CH;
  localparam int unsigned DEPTH  = AUD_DEPTH;
  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
`ifdef AXIS_AUD_CH_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [DATA_W-1:0]    s_tdata;
  logic [TID_W-1:0]     s_tid;
  logic                 s_tvalid;
  logic                 s_tready;
  logic [DATA_W-1:0]    m_tdata;
  logic [TID_W-1:0]     m_tid;
  logic                 m_tvalid;
  logic                 m_tready;
  logic [LVL_W-1:0]     level;
  logic                 ch_err;
  logic [ERR_CNT_W-1:0] ch_err_cnt;

  int checks = 0;
  int errors = 0;
  aud_beat_t q[$];

  always #5 clk = ~clk;

  axis_aud_ch_fifo #(
    .DATA_W (DATA_W),
    .TID_W  (TID_W),
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH)
  ) dut (
    .s_axis_aud_aclk   (clk),
    .s_axis_aud_areset (rst),
    .s_axis_aud_tdata  (s_tdata),
    .s_axis_aud_tid    (s_tid),
    .s_axis_aud_tvalid (s_tvalid),
    .s_axis_aud_tready (s_tready),
    .m_axis_aud_tdata  (m_tdata),
    .m_axis_aud_tid    (m_tid),
    .m_axis_aud_tvalid (m_tvalid),
    .m_axis_aud_tready (m_tready),
    .fifo_level        (level),
    .ch_err            (ch_err),
    .ch_err_cnt        (ch_err_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [TID_W-1:0] t, input logic [DATA_W-1:0] d);
    s_tvalid = v;
    s_tid    = t;
    s_tdata  = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0);
    m_tready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    aud_beat_t b;
    int nxt;
    bit exp_rdy;

    rst = 1'b1;
    drive(1'b0, '0, '0);
    m_tready = 1'b0;
    #1;
    check("rst_tready", 64'(s_tready), 64'(0));
    check("rst_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_level",  64'(level),    64'(0));
    check("rst_errcnt", 64'(ch_err_cnt), 64'(0));
    tick();
    rst = 1'b0;
    #1;
    check("rel_tready_hold", 64'(s_tready), 64'(0));
    tick();
    check("rel_tready_up", 64'(s_tready), 64'(1));

    // Basic L/R pair.
    drive(1'b1, 3'd0, 32'hA);
    tick();
    check("lr_lvl1",   64'(level),    64'(1));
    check("lr_tvalid", 64'(m_tvalid), 64'(1));
    check("lr_d0",     64'(m_tdata),  64'hA);
    drive(1'b1, 3'd1, 32'hB);
    tick();
    drive(1'b0, '0, '0);
    check("lr_lvl2",  64'(level),   64'(2));
    check("lr_hold",  64'(m_tdata), 64'hA);
    check("lr_err",   64'(ch_err),  64'(0));
    m_tready = 1'b1;
    check("lr_tid0",  64'(m_tid),   64'(0));
    tick();
    check("lr_d1",    64'(m_tdata), 64'hB);
    check("lr_tid1",  64'(m_tid),   64'(1));
    check("lr_lvl1b", 64'(level),   64'(1));
    tick();
    check("lr_lvl0",   64'(level),    64'(0));
    check("lr_empty",  64'(m_tvalid), 64'(0));
    check("lr_err2",   64'(ch_err),   64'(0));

    // Fill to full with egress stalled.
    m_tready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      b.tid   = TID_W'(i % 2);
      b.tdata = DATA_W'(32'h100 + i);
      drive(1'b1, b.tid, b.tdata);
      tick();
      q.push_back(b);
    end
    check("full_lvl",    64'(level),    64'(16));
    check("full_tready", 64'(s_tready), 64'(0));
    b.tid = TID_W'(0);
    b.tdata = DATA_W'(32'h110);
    drive(1'b1, b.tid, b.tdata);
    tick();
    check("full_held", 64'(level), 64'(16));
    m_tready = 1'b1;
    check("full_head", 64'(m_tdata), 64'(q[0].tdata));
    tick();
    void'(q.pop_front());
    m_tready = 1'b0;
    check("pop_lvl",    64'(level),    64'(15));
    check("pop_tready", 64'(s_tready), 64'(1));
    tick();
    q.push_back(b);
    check("refill_lvl", 64'(level), 64'(16));

    // Stream with continuous pop while upstream keeps offering beats.
    m_tready = 1'b1;
    nxt = 17;
    for (int c = 0; c < 8; c++) begin
      b.tid   = TID_W'(nxt % 2);
      b.tdata = DATA_W'(32'h100 + nxt);
      drive(1'b1, b.tid, b.tdata);
      exp_rdy = (q.size() != int'(DEPTH));
      check("st_tready", 64'(s_tready), 64'(exp_rdy));
      check("st_level",  64'(level),    64'(q.size()));
      check("st_data",   64'(m_tdata),  64'(q[0].tdata));
      check("st_tid",    64'(m_tid),    64'(q[0].tid));
      tick();
      if (exp_rdy) begin
        q.push_back(b);
        nxt++;
      end
      void'(q.pop_front());
    end
    drive(1'b0, '0, '0);
    for (int c = 0; c < int'(DEPTH) + 2 && q.size() > 0; c++) begin
      check("dr_data", 64'(m_tdata), 64'(q[0].tdata));
      check("dr_tid",  64'(m_tid),   64'(q[0].tid));
      tick();
      void'(q.pop_front());
    end
    check("dr_lvl0",   64'(level),    64'(0));
    check("dr_tvalid", 64'(m_tvalid), 64'(0));
    check("dr_errcnt", 64'(ch_err_cnt), 64'(0));

    // Repeated channel: tid 0,0,1.
    do_reset();
    drive(1'b1, 3'd0, 32'h1);
    tick();
    drive(1'b1, 3'd0, 32'h2);
    tick();
    check("rep_err_pulse", 64'(ch_err), 64'(CHK));
    drive(1'b1, 3'd1, 32'h3);
    tick();
    drive(1'b0, '0, '0);
    check("rep_err_clear", 64'(ch_err),     64'(0));
    check("rep_errcnt",    64'(ch_err_cnt), 64'(CHK ? 1 : 0));
    check("rep_lvl",       64'(level),      64'(CHK ? 2 : 3));
    m_tready = 1'b1;
    check("rep_b0", 64'({m_tid, m_tdata}), 64'({3'd0, 32'h1}));
    tick();
    if (!CHK) begin
      check("rep_b1", 64'({m_tid, m_tdata}), 64'({3'd0, 32'h2}));
      tick();
    end
    check("rep_b2", 64'({m_tid, m_tdata}), 64'({3'd1, 32'h3}));
    tick();
    check("rep_lvl0", 64'(level), 64'(0));

    // Out-of-range channel ID.
    do_reset();
    drive(1'b1, 3'd5, 32'h55);
    tick();
    check("oor_err", 64'(ch_err), 64'(CHK));
    check("oor_lvl", 64'(level),  64'(CHK ? 0 : 1));
    drive(1'b1, 3'd0, 32'h66);
    tick();
    drive(1'b0, '0, '0);
    check("oor_lvl2",   64'(level),      64'(CHK ? 1 : 2));
    check("oor_errcnt", 64'(ch_err_cnt), 64'(CHK ? 1 : 0));
    check("oor_head",   64'(m_tid),      64'(CHK ? 0 : 5));

    // Asynchronous reset mid-burst.
    do_reset();
    drive(1'b1, 3'd3, 32'h30);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, TID_W'(i % 2), DATA_W'(32'h40 + i));
      tick();
    end
    drive(1'b0, '0, '0);
    check("mid_lvl",    64'(level),      64'(CHK ? 7 : 8));
    check("mid_errcnt", 64'(ch_err_cnt), 64'(CHK ? 1 : 0));
    #2;
    rst = 1'b1;
    #1;
    check("arst_tvalid", 64'(m_tvalid),   64'(0));
    check("arst_level",  64'(level),      64'(0));
    check("arst_tready", 64'(s_tready),   64'(0));
    check("arst_errcnt", 64'(ch_err_cnt), 64'(0));
    tick();
    rst = 1'b0;
    tick();
    check("post_tready", 64'(s_tready), 64'(1));
    drive(1'b1, 3'd0, 32'h77);
    tick();
    drive(1'b0, '0, '0);
    check("post_lvl",  64'(level), 64'(1));
    check("post_beat", 64'({m_tid, m_tdata}), 64'({3'd0, 32'h77}));
    check("post_err",  64'(ch_err), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
